// File: rtl/frame_pkg.sv
// Shared frame-buffer geometry and state type, common to the frame writer,
// the frame memory and the VGA reader.
package frame_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 16;
  localparam int FRAME_WORDS  = 4800;
  localparam int WORD_W       = 128;
  localparam int ADDR_W       = 13;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } frameState_e;

endpackage

// File: rtl/frame_writer_if.sv
// Pixel-stream input and frame-memory write port of the frame writer.
// The pixel source is the master; the frame writer is the slave.
interface frame_writer_if #(
  parameter int PIX_W = frame_pkg::PIX_W
);

  logic                          frameStart;
  logic                          pixelValid;
  logic [PIX_W-1:0]              pixelData;
  logic                          pixelReady;
  logic [frame_pkg::ADDR_W-1:0]  writeAddress;
  logic [frame_pkg::WORD_W-1:0]  pixelIn;
  logic                          writeEn;
  logic                          frameDone;
  logic                          frameAbort;

  modport master (
    output frameStart, pixelValid, pixelData,
    input  pixelReady, writeAddress, pixelIn, writeEn, frameDone, frameAbort
  );

  modport slave (
    input  frameStart, pixelValid, pixelData,
    output pixelReady, writeAddress, pixelIn, writeEn, frameDone, frameAbort
  );

endinterface

// File: rtl/frame_writer.sv
// Packs a pixel stream into wide words and writes them, in address order,
// into the frame memory; one frame per frameStart strobe.
module frame_writer #(
  parameter int PIX_W        = frame_pkg::PIX_W,
  parameter int PIX_PER_WORD = frame_pkg::PIX_PER_WORD,
  parameter int FRAME_WORDS  = frame_pkg::FRAME_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_writer_if.slave bus
);

  import frame_pkg::*;

  localparam int                CNT_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  if (PIX_W * PIX_PER_WORD != WORD_W) begin : gBadPacking
    $error("frame_writer: PIX_W * PIX_PER_WORD must equal %0d", WORD_W);
  end
  if (FRAME_WORDS > (1 << ADDR_W) || FRAME_WORDS < 1) begin : gBadFrameSize
    $error("frame_writer: FRAME_WORDS must be in 1..%0d", 1 << ADDR_W);
  end

  frameState_e       state;
  logic [CNT_W-1:0]  pixelCount;
  logic [ADDR_W-1:0] wordCount;
  logic [WORD_W-1:0] wordBuf;
  logic [WORD_W-1:0] completedWord;
  logic              accept;
  logic              wordComplete;
  logic              finalWord;
  logic              abortFrame;

  assign bus.pixelReady = (state == FILL);
  assign accept         = bus.pixelValid && (state == FILL);
  assign wordComplete   = accept && (pixelCount == LAST_SLOT);
  assign finalWord      = (wordCount == LAST_WORD);

  // A word-completing pixel that arrives with frameStart still belongs to the
  // old frame, so a finished frame is never reported as aborted.
  assign abortFrame = bus.frameStart && (state == FILL) &&
                      ((pixelCount != '0) || (wordCount != '0)) &&
                      !(wordComplete && finalWord);

  always_comb begin
    completedWord = wordBuf;
    completedWord[(PIX_PER_WORD-1)*PIX_W +: PIX_W] = bus.pixelData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pixelCount       <= '0;
      wordCount        <= '0;
      wordBuf          <= '0;
      bus.writeEn      <= 1'b0;
      bus.frameDone    <= 1'b0;
      bus.frameAbort   <= 1'b0;
      bus.writeAddress <= '0;
      bus.pixelIn      <= '0;
    end else begin
      bus.writeEn    <= 1'b0;
      bus.frameDone  <= 1'b0;
      bus.frameAbort <= abortFrame;

      if (wordComplete) begin
        bus.writeEn      <= 1'b1;
        bus.pixelIn      <= completedWord;
        bus.writeAddress <= wordCount;
        bus.frameDone    <= finalWord;
      end

      // Otherwise a pixel arriving with frameStart is pixel 0 of the new frame.
      if (bus.frameStart) begin
        state     <= FILL;
        wordCount <= '0;
        if (accept && !wordComplete) begin
          wordBuf    <= WORD_W'(bus.pixelData);
          pixelCount <= CNT_W'(1);
        end else begin
          wordBuf    <= '0;
          pixelCount <= '0;
        end
      end else if (wordComplete) begin
        wordBuf    <= '0;
        pixelCount <= '0;
        if (finalWord) begin
          state <= DONE;
        end else begin
          wordCount <= wordCount + ADDR_W'(1);
        end
      end else if (accept) begin
        wordBuf[int'(pixelCount)*PIX_W +: PIX_W] <= bus.pixelData;
        pixelCount <= pixelCount + CNT_W'(1);
      end
    end
  end

endmodule
